spart_bus_arbiter: RTL and testbench

SPART_BUS_ARBITER -- requirements
Module: spart_bus_arbiter

---
 rtl/spart_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_spart_bus_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_arbiter.sv
// SPART bus arbiter: programs the baud divisor, services received bytes and
// arbitrates two transmit clients onto a single one-cycle-per-access SPART bus.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// CFG_LO   | write low divisor byte (addr 10) for the live br_cfg
// CFG_HI   | write high divisor byte (addr 11) for the latched cfg_reg
// IDLE     | bus idle; choose read, write or reprogram
// RX_READ  | read data register (addr 00) into rx_data
// TX_WRITE | write granted client's byte to data register, ack that client
// TX_HOLD  | one dead cycle so a stale tbr cannot trigger a second write
module spart_bus_arbiter #(
  parameter bit RX_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       cfg_done
);

  typedef enum logic [2:0] {
    CFG_LO   = 3'd0,
    CFG_HI   = 3'd1,
    IDLE     = 3'd2,
    RX_READ  = 3'd3,
    TX_WRITE = 3'd4,
    TX_HOLD  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       pri_q, pri_d;
  logic [1:0] cfg_reg_q, cfg_reg_d;
  logic       cfg_done_q, cfg_done_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;

  logic       rx_go;
  logic       tx_go;
  logic       bus_drive;
  logic [7:0] bus_out;

  assign rx_go = rda;
  assign tx_go = tbr & (req0 | req1);

  function automatic logic [7:0] div_lo(input logic [1:0] sel);
    case (sel)
      2'b00:   div_lo = 8'hC0;
      2'b01:   div_lo = 8'h80;
      default: div_lo = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] div_hi(input logic [1:0] sel);
    case (sel)
      2'b00:   div_hi = 8'h12;
      2'b01:   div_hi = 8'h25;
      2'b10:   div_hi = 8'h4B;
      default: div_hi = 8'h96;
    endcase
  endfunction

  // State and datapath registers; reset lands in CFG_LO so the divisor is
  // always reprogrammed first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CFG_LO;
      gnt_q      <= 1'b0;
      pri_q      <= 1'b0;
      cfg_reg_q  <= 2'b00;
      cfg_done_q <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      pri_q      <= pri_d;
      cfg_reg_q  <= cfg_reg_d;
      cfg_done_q <= cfg_done_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Next-state, grant latch, round-robin pointer and configuration tracking.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    pri_d      = pri_q;
    cfg_reg_d  = cfg_reg_q;
    cfg_done_d = cfg_done_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (state_q)
      CFG_LO: begin
        cfg_reg_d  = br_cfg;
        cfg_done_d = 1'b0;
        state_d    = CFG_HI;
      end
      CFG_HI: begin
        cfg_done_d = 1'b1;
        state_d    = IDLE;
      end
      IDLE: begin
        if (RX_FIRST && rx_go) begin
          state_d = RX_READ;
        end else if (tx_go) begin
          // Both requesting: pointer decides; otherwise the sole requester.
          gnt_d   = (req0 & req1) ? pri_q : req1;
          state_d = TX_WRITE;
        end else if (rx_go) begin
          state_d = RX_READ;
        end else if (br_cfg != cfg_reg_q) begin
          // Drop cfg_done while the reprogram sequence is on the bus.
          cfg_done_d = 1'b0;
          state_d    = CFG_LO;
        end
      end
      RX_READ: begin
        rx_data_d  = databus;
        rx_valid_d = 1'b1;
        state_d    = IDLE;
      end
      TX_WRITE: begin
        pri_d   = ~gnt_q;
        state_d = TX_HOLD;
      end
      TX_HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = CFG_LO;
      end
    endcase
  end

  // Bus outputs decoded from state; gated by rst_n so reset releases the bus
  // immediately even though the reset state is an access state.
  always_comb begin
    iocs      = 1'b0;
    iorw      = 1'b1;
    ioaddr    = 2'b00;
    bus_drive = 1'b0;
    bus_out   = 8'h00;
    ack0      = 1'b0;
    ack1      = 1'b0;
    if (rst_n) begin
      case (state_q)
        CFG_LO: begin
          iocs      = 1'b1;
          iorw      = 1'b0;
          ioaddr    = 2'b10;
          bus_drive = 1'b1;
          bus_out   = div_lo(br_cfg);
        end
        CFG_HI: begin
          iocs      = 1'b1;
          iorw      = 1'b0;
          ioaddr    = 2'b11;
          bus_drive = 1'b1;
          bus_out   = div_hi(cfg_reg_q);
        end
        RX_READ: begin
          iocs = 1'b1;
        end
        TX_WRITE: begin
          iocs      = 1'b1;
          iorw      = 1'b0;
          bus_drive = 1'b1;
          bus_out   = gnt_q ? data1 : data0;
          ack0      = ~gnt_q;
          ack1      = gnt_q;
        end
        default: begin
          iocs = 1'b0;
        end
      endcase
    end
  end

  assign databus  = bus_drive ? bus_out : 8'hzz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter: divisor programming, receive, round-robin
// transmit, receive-before-transmit priority, baud change and mid-access reset.
module tb_spart_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       ack0, ack1;
  logic       rda, tbr;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cfg_done;
  logic [7:0] spart_rd;

  int checks = 0;
  int errors = 0;

  spart_bus_arbiter #(.RX_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .br_cfg   (br_cfg),
    .req0     (req0),
    .req1     (req1),
    .data0    (data0),
    .data1    (data1),
    .ack0     (ack0),
    .ack1     (ack1),
    .rda      (rda),
    .tbr      (tbr),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cfg_done (cfg_done)
  );

  // SPART side of the bus: drives the data register only during a read.
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? spart_rd : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle; acks must never collide.
  task automatic step();
    @(posedge clk);
    #1;
    chk("ack_excl", {31'd0, ack0 & ack1}, 32'd0);
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_iocs"}, {31'd0, iocs}, 32'd0);
    chk({tag, "_iorw"}, {31'd0, iorw}, 32'd1);
    chk({tag, "_addr"}, {30'd0, ioaddr}, 32'd0);
  endtask

  task automatic chk_write(input string tag, input logic [1:0] addr, input logic [7:0] d);
    chk({tag, "_iocs"}, {31'd0, iocs}, 32'd1);
    chk({tag, "_iorw"}, {31'd0, iorw}, 32'd0);
    chk({tag, "_addr"}, {30'd0, ioaddr}, {30'd0, addr});
    chk({tag, "_data"}, {24'd0, databus}, {24'd0, d});
  endtask

  initial begin
    rst_n = 1'b0; br_cfg = 2'b01; req0 = 1'b0; req1 = 1'b0;
    data0 = 8'h31; data1 = 8'h32; rda = 1'b0; tbr = 1'b0; spart_rd = 8'h00;
    step(); step();

    // Reset state
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk_idle_bus("rst_bus");

    // Divisor programming after release, br_cfg=01
    rst_n = 1'b1;
    #1;
    chk_write("cfg_lo", 2'b10, 8'h80);
    chk("cfg_lo_done", {31'd0, cfg_done}, 32'd0);
    step();
    chk_write("cfg_hi", 2'b11, 8'h25);
    chk("cfg_hi_done", {31'd0, cfg_done}, 32'd0);
    step();
    chk("cfg_done_set", {31'd0, cfg_done}, 32'd1);
    chk_idle_bus("idle0");

    // Receive one byte
    rda = 1'b1; spart_rd = 8'h41;
    step();
    chk("rx_iocs", {31'd0, iocs}, 32'd1);
    chk("rx_iorw", {31'd0, iorw}, 32'd1);
    chk("rx_addr", {30'd0, ioaddr}, 32'd0);
    chk("rx_valid_early", {31'd0, rx_valid}, 32'd0);
    rda = 1'b0;
    step();
    chk("rx_data", {24'd0, rx_data}, 32'h41);
    chk("rx_valid_pulse", {31'd0, rx_valid}, 32'd1);
    chk_idle_bus("rx_after");
    step();
    chk("rx_valid_once", {31'd0, rx_valid}, 32'd0);
    chk("rx_data_hold", {24'd0, rx_data}, 32'h41);

    // Round-robin writes, both clients requesting
    req0 = 1'b1; req1 = 1'b1; tbr = 1'b1;
    step();
    chk_write("tx1", 2'b00, 8'h31);
    chk("tx1_ack0", {31'd0, ack0}, 32'd1);
    chk("tx1_ack1", {31'd0, ack1}, 32'd0);
    step();
    chk_idle_bus("tx1_hold");
    chk("tx1_hold_ack0", {31'd0, ack0}, 32'd0);
    step();
    chk_idle_bus("tx1_idle");
    step();
    chk_write("tx2", 2'b00, 8'h32);
    chk("tx2_ack0", {31'd0, ack0}, 32'd0);
    chk("tx2_ack1", {31'd0, ack1}, 32'd1);
    step(); step();
    step();
    chk_write("tx3", 2'b00, 8'h31);
    chk("tx3_ack0", {31'd0, ack0}, 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();
    chk_idle_bus("tx_done");

    // rda, tbr and req1 together: read first, then write data1
    rda = 1'b1; tbr = 1'b1; req1 = 1'b1; spart_rd = 8'h5A;
    step();
    chk("both_rx_iorw", {31'd0, iorw}, 32'd1);
    chk("both_rx_iocs", {31'd0, iocs}, 32'd1);
    chk("both_rx_ack1", {31'd0, ack1}, 32'd0);
    rda = 1'b0;
    step();
    chk("both_rx_data", {24'd0, rx_data}, 32'h5A);
    chk("both_rx_valid", {31'd0, rx_valid}, 32'd1);
    step();
    chk_write("both_tx", 2'b00, 8'h32);
    chk("both_tx_ack1", {31'd0, ack1}, 32'd1);
    chk("both_tx_ack0", {31'd0, ack0}, 32'd0);
    req1 = 1'b0;
    step(); step();

    // Baud change 01 -> 11 from IDLE
    br_cfg = 2'b11;
    step();
    chk_write("rcfg_lo", 2'b10, 8'h00);
    chk("rcfg_lo_done", {31'd0, cfg_done}, 32'd0);
    step();
    chk_write("rcfg_hi", 2'b11, 8'h96);
    chk("rcfg_hi_done", {31'd0, cfg_done}, 32'd0);
    step();
    chk("rcfg_done", {31'd0, cfg_done}, 32'd1);
    chk_idle_bus("rcfg_idle");

    // Reset asserted during TX_WRITE
    req0 = 1'b1; data0 = 8'hA5;
    step();
    chk_write("rtx", 2'b00, 8'hA5);
    chk("rtx_ack0", {31'd0, ack0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rtx_abort_ack0", {31'd0, ack0}, 32'd0);
    chk_idle_bus("rtx_abort");
    chk("rtx_abort_done", {31'd0, cfg_done}, 32'd0);
    step();
    chk("rtx_hold_ack0", {31'd0, ack0}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk_write("rtx_cfg_lo", 2'b10, 8'h00);
    chk("rtx_cfg_lo_ack0", {31'd0, ack0}, 32'd0);
    step();
    chk_write("rtx_cfg_hi", 2'b11, 8'h96);
    step();
    chk("rtx_cfg_done", {31'd0, cfg_done}, 32'd1);
    chk_idle_bus("rtx_idle");
    step();
    chk_write("rtx_retx", 2'b00, 8'hA5);
    chk("rtx_retx_ack0", {31'd0, ack0}, 32'd1);
    req0 = 1'b0; tbr = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
